// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI arbiter and its round-robin picker.
package spi_pkg;

    localparam int NUM_REQ = 3;
    localparam int BYTE_W  = 8;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Successor of a requester index, wrapping after the last requester.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_arbiter
    import spi_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between three requesters: round-robin grant, held start pulse,
// completion on release of the selected chip select, abort on timeout.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no transfer; grants a request when enable is high
// ST_START | m_start held high for START_HOLD cycles
// ST_WAIT  | waiting for the selected chip select to go low and return high
// ST_DONE  | one-cycle response pulse, then back to idle
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int START_HOLD = 30,
    parameter int TIMEOUT    = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rsp_valid,
    output logic [IDX_W-1:0]          rsp_id,
    output logic [BYTE_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      m_start,
    output logic                      m_en,
    output logic [IDX_W-1:0]          m_slaveselect,
    output logic [BYTE_W-1:0]         m_data_in,
    input  logic [BYTE_W-1:0]         m_data_out,
    input  logic [NUM_REQ-1:0]        m_cs_n
);

    localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(START_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT - 1);

    state_t              state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    cur_idx;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                seen_low;

    logic                arb_valid;
    logic [IDX_W-1:0]    arb_idx;
    logic [BYTE_W-1:0]   sel_byte;
    logic                cs_sel;

    rr_arbiter u_rr (
        .req   (req),
        .ptr   (ptr),
        .valid (arb_valid),
        .index (arb_idx)
    );

    always_comb begin
        sel_byte = req_data[BYTE_W-1:0];
        case (arb_idx)
            2'd1:    sel_byte = req_data[2*BYTE_W-1:BYTE_W];
            2'd2:    sel_byte = req_data[3*BYTE_W-1:2*BYTE_W];
            default: sel_byte = req_data[BYTE_W-1:0];
        endcase
    end

    assign cs_sel = m_cs_n[cur_idx];
    assign m_en   = enable;

    // Timers count down from their load value; reaching zero is the terminal event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            cur_idx       <= '0;
            hold_cnt      <= '0;
            tmo_cnt       <= '0;
            seen_low      <= 1'b0;
            gnt           <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            busy          <= 1'b0;
            m_start       <= 1'b0;
            m_slaveselect <= '0;
            m_data_in     <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && arb_valid) begin
                        state         <= ST_START;
                        cur_idx       <= arb_idx;
                        ptr           <= rr_next(arb_idx);
                        gnt           <= NUM_REQ'(1) << arb_idx;
                        m_slaveselect <= arb_idx;
                        m_data_in     <= sel_byte;
                        m_start       <= 1'b1;
                        busy          <= 1'b1;
                        seen_low      <= 1'b0;
                        hold_cnt      <= HOLD_LOAD;
                        tmo_cnt       <= TMO_LOAD;
                    end
                end
                ST_START: begin
                    if (!cs_sel) begin
                        seen_low <= 1'b1;
                    end
                    if (tmo_cnt == '0) begin
                        state     <= ST_DONE;
                        m_start   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_idx;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                        if (hold_cnt == '0) begin
                            state   <= ST_WAIT;
                            m_start <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!cs_sel) begin
                        seen_low <= 1'b1;
                    end
                    // A completion seen on the final cycle wins over the abort.
                    if (seen_low && cs_sel) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_idx;
                        rsp_data  <= m_data_out;
                        rsp_err   <= 1'b0;
                    end else if (tmo_cnt == '0) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_idx;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    busy          <= 1'b0;
                    m_slaveselect <= '0;
                    m_data_in     <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
